// File: rtl/coherence_bus_ctrl.sv
//==============================================================================
// Module      : coherence_bus_ctrl
// Description : Responder end of the dcache<->bus coherence protocol for two
//               MSI dcaches sharing one single-ported RAM. Arbitrates the two
//               cores, snoops the other core (ccwait/ccinv/ccsnoopaddr), moves
//               2-word blocks RAM->cache or cache->cache (updating RAM on a
//               forward) and serialises write-backs. One block in flight.
// Ports       : CLK, nRST          clock / async active-low reset
//               dREN, dWEN         per-core block read / write-back request
//               daddr, dstore      per-core word address / store-forward data
//               cctrans, ccwrite   per-core coherence start or snoop dirty-hit
//                                  response / ownership request
//               dwait, dload       per-core stall (one-cycle low per word)
//                                  and load data
//               ccwait, ccinv,     snoop hold, invalidate and block address
//               ccsnoopaddr        presented to the snooped core
//               ramREN, ramWEN,    RAM request, address, write data
//               ramaddr, ramstore
//               ramload, ramwait   RAM read data and busy
//               stat_c2c, stat_inv, stat_wb (only with BUS_STATS_EN)
// Config      : define BUS_STATS_EN to add saturating transaction counters.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module coherence_bus_ctrl #(
    parameter int WORD_W    = 32,
    parameter int SNOOP_LAT = 1
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [1:0]          dREN,
    input  logic [1:0]          dWEN,
    input  logic [2*WORD_W-1:0] daddr,
    input  logic [2*WORD_W-1:0] dstore,
    input  logic [1:0]          cctrans,
    input  logic [1:0]          ccwrite,
    output logic [1:0]          dwait,
    output logic [2*WORD_W-1:0] dload,
    output logic [1:0]          ccwait,
    output logic [1:0]          ccinv,
    output logic [2*WORD_W-1:0] ccsnoopaddr,
    output logic                ramREN,
    output logic                ramWEN,
    output logic [WORD_W-1:0]   ramaddr,
    output logic [WORD_W-1:0]   ramstore,
    input  logic [WORD_W-1:0]   ramload,
    input  logic                ramwait
`ifdef BUS_STATS_EN
    ,
    output logic [31:0]         stat_c2c,
    output logic [31:0]         stat_inv,
    output logic [31:0]         stat_wb
`endif
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WB0  = 3'd1,
        WB1  = 3'd2,
        SNP  = 3'd3,
        RD0  = 3'd4,
        RD1  = 3'd5,
        C2C0 = 3'd6,
        C2C1 = 3'd7
    } state_t;

    localparam logic [7:0] SNP_LAST = 8'(SNOOP_LAT - 1);

    state_t              state;
    state_t              adv_state;
    logic                rr_last;
    logic                req_id;
    logic                oth_id;
    logic [WORD_W-4:0]   blk_addr;
    logic                is_read;
    logic                hold;
    logic [7:0]          snp_cnt;

    logic [1:0]          req;
    logic                win;
    logic [WORD_W-1:0]   addr0, addr1, store0, store1;
    logic [WORD_W-1:0]   win_addr;
    logic [WORD_W-1:0]   own_store, oth_store;
    logic                rd_state, c2c_state, word_state, word_sel;
    logic                done_word, inv_done;
    logic                unused_lsbs;

    assign addr0     = daddr[WORD_W-1:0];
    assign addr1     = daddr[2*WORD_W-1:WORD_W];
    assign store0    = dstore[WORD_W-1:0];
    assign store1    = dstore[2*WORD_W-1:WORD_W];
    assign oth_id    = ~req_id;
    assign own_store = req_id ? store1 : store0;
    assign oth_store = req_id ? store0 : store1;

    // A snooped core raises cctrans as its answer to ccwait, so it is not a new request.
    assign req = dREN | dWEN | (cctrans & ~ccwait);

    always_comb begin
        win = 1'b0;
        if (req[0] && req[1]) begin
            win = ~rr_last;
        end else if (req[1]) begin
            win = 1'b1;
        end
    end

    assign win_addr    = win ? addr1 : addr0;
    assign unused_lsbs = ^win_addr[2:0];

    assign rd_state   = (state == RD0)  || (state == RD1);
    assign c2c_state  = (state == C2C0) || (state == C2C1);
    assign word_state = (state != IDLE) && (state != SNP);
    assign word_sel   = (state == WB1)  || (state == RD1) || (state == C2C1);

    // A RAM access finishes on the cycle its request is up and ramwait is low.
    assign done_word = word_state && !hold && (ramREN || ramWEN) && !ramwait;
    assign inv_done  = (state == SNP) && (snp_cnt == SNP_LAST) && !cctrans[oth_id] && !is_read;

    always_comb begin
        adv_state = IDLE;
        case (state)
            WB0:     adv_state = WB1;
            RD0:     adv_state = RD1;
            C2C0:    adv_state = C2C1;
            default: adv_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            rr_last     <= 1'b1;
            req_id      <= 1'b0;
            blk_addr    <= '0;
            is_read     <= 1'b0;
            hold        <= 1'b0;
            snp_cnt     <= '0;
            dwait       <= 2'b11;
            dload       <= '0;
            ccwait      <= 2'b00;
            ccinv       <= 2'b00;
            ccsnoopaddr <= '0;
            ramREN      <= 1'b0;
            ramWEN      <= 1'b0;
            ramaddr     <= '0;
            ramstore    <= '0;
        end else begin
            dwait <= 2'b11;
            case (state)
                IDLE: begin
                    // The cycle after a dwait pulse the finishing core still shows
                    // its old request, so arbitration skips that cycle.
                    if (hold) begin
                        hold <= 1'b0;
                    end else if (|req) begin
                        req_id   <= win;
                        rr_last  <= win;
                        blk_addr <= win_addr[WORD_W-1:3];
                        is_read  <= dREN[win];
                        if (dWEN[win]) begin
                            state <= WB0;
                        end else begin
                            state   <= SNP;
                            snp_cnt <= '0;
                            ccwait  <= win ? 2'b01 : 2'b10;
                            ccinv   <= ccwrite[win] ? (win ? 2'b01 : 2'b10) : 2'b00;
                            if (win) begin
                                ccsnoopaddr[WORD_W-1:0] <= {win_addr[WORD_W-1:3], 3'b000};
                            end else begin
                                ccsnoopaddr[2*WORD_W-1:WORD_W] <= {win_addr[WORD_W-1:3], 3'b000};
                            end
                        end
                    end
                end

                SNP: begin
                    if (snp_cnt == SNP_LAST) begin
                        if (cctrans[oth_id]) begin
                            state <= C2C0;
                        end else if (is_read) begin
                            state <= RD0;
                        end else begin
                            // Upgrade only: acknowledge once, no data moves.
                            dwait  <= req_id ? 2'b01 : 2'b10;
                            ccwait <= 2'b00;
                            ccinv  <= 2'b00;
                            hold   <= 1'b1;
                            state  <= IDLE;
                        end
                    end else begin
                        snp_cnt <= snp_cnt + 8'd1;
                    end
                end

                default: begin
                    // Word engine shared by WB/RD/C2C. After each completed word the
                    // request stays down for the pulse cycle plus one more, so the
                    // supplying cache has moved on to the next word before dstore
                    // is captured.
                    if (hold) begin
                        hold <= 1'b0;
                    end else if (!ramREN && !ramWEN) begin
                        ramaddr <= {blk_addr, word_sel, 2'b00};
                        if (rd_state) begin
                            ramREN <= 1'b1;
                        end else begin
                            ramWEN   <= 1'b1;
                            ramstore <= c2c_state ? oth_store : own_store;
                        end
                    end else if (!ramwait) begin
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        hold   <= 1'b1;
                        if (c2c_state) begin
                            dwait <= 2'b00;
                        end else begin
                            dwait <= req_id ? 2'b01 : 2'b10;
                        end
                        if (rd_state || c2c_state) begin
                            if (req_id) begin
                                dload[2*WORD_W-1:WORD_W] <= rd_state ? ramload : ramstore;
                            end else begin
                                dload[WORD_W-1:0] <= rd_state ? ramload : ramstore;
                            end
                        end
                        if (word_sel) begin
                            ccwait <= 2'b00;
                            ccinv  <= 2'b00;
                            state  <= IDLE;
                        end else begin
                            state <= adv_state;
                        end
                    end
                end
            endcase
        end
    end

`ifdef BUS_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_c2c <= '0;
            stat_inv <= '0;
            stat_wb  <= '0;
        end else begin
            if (done_word && (state == C2C1) && (stat_c2c != 32'hFFFF_FFFF)) begin
                stat_c2c <= stat_c2c + 32'd1;
            end
            if (inv_done && (stat_inv != 32'hFFFF_FFFF)) begin
                stat_inv <= stat_inv + 32'd1;
            end
            if (done_word && (state == WB1) && (stat_wb != 32'hFFFF_FFFF)) begin
                stat_wb <= stat_wb + 32'd1;
            end
        end
    end
`else
    logic unused_events;
    assign unused_events = done_word ^ inv_done;
`endif

endmodule

`default_nettype wire

// File: tb/tb_coherence_bus_ctrl.sv
//==============================================================================
// Module      : tb_coherence_bus_ctrl
// Description : Directed self-checking bench for coherence_bus_ctrl with a
//               2-wait-state RAM model and scripted cache behaviour.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_coherence_bus_ctrl;

    localparam int RAM_LAT = 2;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [1:0]  dREN = '0, dWEN = '0, cctrans = '0, ccwrite = '0;
    logic [63:0] daddr = '0, dstore = '0;
    logic [1:0]  dwait, ccwait, ccinv;
    logic [63:0] dload, ccsnoopaddr;
    logic        ramREN, ramWEN, ramwait;
    logic [31:0] ramaddr, ramstore, ramload;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    coherence_bus_ctrl dut (
        .CLK(CLK), .nRST(nRST), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
        .dstore(dstore), .cctrans(cctrans), .ccwrite(ccwrite), .dwait(dwait),
        .dload(dload), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramwait(ramwait)
    );

    // RAM model: unwritten words come from a fixed preload table
    logic [31:0] mem [0:255];
    logic        wr_vld [0:255] = '{default: 1'b0};
    int          ram_cnt = 0;
    int          both_n  = 0;
    logic [31:0] rd_q[$], wa_q[$], wd_q[$];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        case (a)
            32'h100: init_val = 32'h1111_0000;
            32'h104: init_val = 32'h1111_0004;
            32'h180: init_val = 32'hA0A0_0000;
            32'h184: init_val = 32'hA0A0_0004;
            32'h1C0: init_val = 32'hB0B0_0000;
            32'h1C4: init_val = 32'hB0B0_0004;
            default: init_val = 32'hBAD0_0000 | a;
        endcase
    endfunction

    assign ramwait = !((ramREN || ramWEN) && (ram_cnt == RAM_LAT));
    assign ramload = wr_vld[ramaddr[9:2]] ? mem[ramaddr[9:2]] : init_val(ramaddr);

    always @(posedge CLK) begin
        if (ramREN && ramWEN) both_n++;
        if (ramREN || ramWEN) begin
            if (ram_cnt == RAM_LAT) begin
                ram_cnt <= 0;
                if (ramWEN) begin
                    mem[ramaddr[9:2]]    <= ramstore;
                    wr_vld[ramaddr[9:2]] <= 1'b1;
                    wa_q.push_back(ramaddr);
                    wd_q.push_back(ramstore);
                end else begin
                    rd_q.push_back(ramaddr);
                end
            end else begin
                ram_cnt <= ram_cnt + 1;
            end
        end else begin
            ram_cnt <= 0;
        end
    end

    task automatic idle_inputs();
        dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0; daddr = '0; dstore = '0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        idle_inputs();
        repeat (2) @(negedge CLK);
        total++; if (dwait !== 2'b11) begin bad++; $display("FAIL reset_dwait: got %b want 11", dwait); end
        total++; if (ccwait !== 2'b00) begin bad++; $display("FAIL reset_ccwait: got %b want 00", ccwait); end
        total++; if (ccinv !== 2'b00) begin bad++; $display("FAIL reset_ccinv: got %b want 00", ccinv); end
        total++; if (ccsnoopaddr !== 64'h0) begin bad++; $display("FAIL reset_snoopaddr: got %h want 0", ccsnoopaddr); end
        total++; if (dload !== 64'h0) begin bad++; $display("FAIL reset_dload: got %h want 0", dload); end
        total++; if ({ramREN, ramWEN} !== 2'b00) begin bad++; $display("FAIL reset_ramreq: got %b want 00", {ramREN, ramWEN}); end
        total++; if ({ramaddr, ramstore} !== 64'h0) begin bad++; $display("FAIL reset_ramaddr_store: got %h want 0", {ramaddr, ramstore}); end
        nRST = 1'b1;
        @(negedge CLK);
    endtask

    // Two ties in a row right after reset: core0, then core1, then core0 again.
    task automatic test_back_to_back();
        for (int rnd = 0; rnd < 2; rnd++) begin
            int          c0, c1;
            int          order[$];
            logic [31:0] g0 [2];
            logic [31:0] g1 [2];
            c0 = 0; c1 = 0;
            daddr = {32'h0000_01C0, 32'h0000_0180};
            dREN  = 2'b11;
            for (int c = 0; c < 300 && order.size() < 2; c++) begin
                @(negedge CLK);
                if (!dwait[0] && dREN[0]) begin
                    g0[c0] = dload[31:0]; c0++;
                    if (c0 == 2) begin dREN[0] = 1'b0; order.push_back(0); end
                end
                if (!dwait[1] && dREN[1]) begin
                    g1[c1] = dload[63:32]; c1++;
                    if (c1 == 2) begin dREN[1] = 1'b0; order.push_back(1); end
                end
            end
            dREN = 2'b00;
            total++; if (order.size() != 2) begin bad++; $display("FAIL tie_timeout round %0d: served %0d want 2", rnd, order.size()); end
            total++; if (order.size() == 2 && !(order[0] == 0 && order[1] == 1)) begin
                bad++; $display("FAIL tie_order round %0d: got %0d,%0d want 0,1", rnd, order[0], order[1]);
            end
            total++; if ({g0[0], g0[1]} !== {32'hA0A0_0000, 32'hA0A0_0004}) begin
                bad++; $display("FAIL tie_core0_data round %0d: got %h %h want a0a00000 a0a00004", rnd, g0[0], g0[1]);
            end
            total++; if ({g1[0], g1[1]} !== {32'hB0B0_0000, 32'hB0B0_0004}) begin
                bad++; $display("FAIL tie_core1_data round %0d: got %h %h want b0b00000 b0b00004", rnd, g1[0], g1[1]);
            end
            repeat (2) @(negedge CLK);
        end
    endtask

    // Core0 read miss, core1 does not hold the block; low address bits ignored.
    task automatic test_read();
        int          k, rb, wb;
        logic [31:0] got [2];
        logic [31:0] snp;
        bit          inv_seen, w0_seen;
        k = 0; snp = '0; inv_seen = 0; w0_seen = 0;
        rb = rd_q.size(); wb = wa_q.size();
        daddr[31:0] = 32'h0000_0106;
        dREN[0]     = 1'b1;
        for (int c = 0; c < 100 && k < 2; c++) begin
            @(negedge CLK);
            if (ccinv != 2'b00) inv_seen = 1;
            if (ccwait[0]) w0_seen = 1;
            if (ccwait[1]) snp = ccsnoopaddr[63:32];
            if (!dwait[0]) begin got[k] = dload[31:0]; k++; end
        end
        dREN = 2'b00;
        total++; if (k != 2) begin bad++; $display("FAIL read_timeout: words %0d want 2", k); end
        total++; if (got[0] !== 32'h1111_0000) begin bad++; $display("FAIL read_word0: got %h want 11110000", got[0]); end
        total++; if (got[1] !== 32'h1111_0004) begin bad++; $display("FAIL read_word1: got %h want 11110004", got[1]); end
        total++; if (snp !== 32'h100) begin bad++; $display("FAIL read_snoopaddr: got %h want 00000100", snp); end
        total++; if (inv_seen || w0_seen) begin bad++; $display("FAIL read_snoop_flags: inv=%0d self_wait=%0d want 0 0", inv_seen, w0_seen); end
        total++; if (rd_q.size() - rb != 2 || rd_q[rb] !== 32'h100 || rd_q[rb+1] !== 32'h104 || wa_q.size() != wb) begin
            bad++; $display("FAIL read_ram_seq: reads %0d writes %0d want 2 reads 100,104 and 0 writes", rd_q.size() - rb, wa_q.size() - wb);
        end
        repeat (2) @(negedge CLK);
    endtask

    // Core1 holds 0x100 Modified; core0 write miss gets it cache-to-cache.
    task automatic test_c2c();
        int          k, k1, rb, wb, unpaired, inv_gap;
        logic [31:0] got [2];
        k = 0; k1 = 0; unpaired = 0; inv_gap = 0;
        rb = rd_q.size(); wb = wa_q.size();
        daddr[31:0] = 32'h0000_0100;
        ccwrite[0]  = 1'b1;
        dREN[0]     = 1'b1;
        for (int c = 0; c < 200 && k < 2; c++) begin
            @(negedge CLK);
            if (dwait[0] !== dwait[1]) unpaired++;
            if (ccwait[1] && !ccinv[1]) inv_gap++;
            if (!dwait[1]) k1++;
            if (!dwait[0]) begin got[k] = dload[31:0]; k++; end
            if (ccwait[1]) begin
                cctrans[1]    = 1'b1;
                dstore[63:32] = (k1 == 0) ? 32'hDEAD_BEEF : 32'hCAFE_F00D;
            end else begin
                cctrans[1] = 1'b0;
            end
        end
        idle_inputs();
        total++; if (k != 2) begin bad++; $display("FAIL c2c_timeout: words %0d want 2", k); end
        total++; if ({got[0], got[1]} !== {32'hDEAD_BEEF, 32'hCAFE_F00D}) begin
            bad++; $display("FAIL c2c_dload: got %h %h want deadbeef cafef00d", got[0], got[1]);
        end
        total++; if (unpaired != 0 || k1 != 2) begin bad++; $display("FAIL c2c_dwait_pair: unpaired %0d core1 pulses %0d want 0 and 2", unpaired, k1); end
        total++; if (inv_gap != 0) begin bad++; $display("FAIL c2c_ccinv_held: cycles without ccinv %0d want 0", inv_gap); end
        total++; if (wa_q.size() - wb != 2 || wa_q[wb] !== 32'h100 || wd_q[wb] !== 32'hDEAD_BEEF ||
                     wa_q[wb+1] !== 32'h104 || wd_q[wb+1] !== 32'hCAFE_F00D || rd_q.size() != rb) begin
            bad++; $display("FAIL c2c_ram_update: writes %0d reads %0d want 100=deadbeef 104=cafef00d, no reads", wa_q.size() - wb, rd_q.size() - rb);
        end
        repeat (2) @(negedge CLK);
    endtask

    // Core0 S->M upgrade: invalidate only, no data moved.
    task automatic test_inv();
        int          inv_cyc, dw_cyc, rb, wb;
        logic [31:0] snp;
        inv_cyc = 0; dw_cyc = 0; snp = '0;
        rb = rd_q.size(); wb = wa_q.size();
        daddr[31:0] = 32'h0000_0200;
        ccwrite[0]  = 1'b1;
        cctrans[0]  = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            if (ccinv[1]) begin inv_cyc++; snp = ccsnoopaddr[63:32]; end
            if (!dwait[0]) begin dw_cyc++; cctrans[0] = 1'b0; ccwrite[0] = 1'b0; end
        end
        idle_inputs();
        total++; if (inv_cyc != 1) begin bad++; $display("FAIL inv_ccinv_cycles: got %0d want 1", inv_cyc); end
        total++; if (dw_cyc != 1) begin bad++; $display("FAIL inv_dwait_cycles: got %0d want 1", dw_cyc); end
        total++; if (snp !== 32'h200) begin bad++; $display("FAIL inv_snoopaddr: got %h want 00000200", snp); end
        total++; if (rd_q.size() != rb || wa_q.size() != wb) begin
            bad++; $display("FAIL inv_no_ram: reads %0d writes %0d want 0 0", rd_q.size() - rb, wa_q.size() - wb);
        end
    endtask

    // Core0 write-back of 0x300: no snoop, two RAM writes.
    task automatic test_wb();
        int k, rb, wb;
        bit snooped;
        k = 0; snooped = 0;
        rb = rd_q.size(); wb = wa_q.size();
        daddr[31:0]  = 32'h0000_0300;
        dstore[31:0] = 32'h0000_0011;
        dWEN[0]      = 1'b1;
        for (int c = 0; c < 100 && k < 2; c++) begin
            @(negedge CLK);
            if (ccwait != 2'b00) snooped = 1;
            if (!dwait[0]) begin
                k++;
                daddr[31:0]  = 32'h0000_0304;
                dstore[31:0] = 32'h0000_0022;
            end
        end
        idle_inputs();
        total++; if (k != 2) begin bad++; $display("FAIL wb_timeout: words %0d want 2", k); end
        total++; if (snooped) begin bad++; $display("FAIL wb_ccwait: got asserted want never"); end
        total++; if (wa_q.size() - wb != 2 || wa_q[wb] !== 32'h300 || wd_q[wb] !== 32'h11 ||
                     wa_q[wb+1] !== 32'h304 || wd_q[wb+1] !== 32'h22 || rd_q.size() != rb) begin
            bad++; $display("FAIL wb_ram_writes: writes %0d reads %0d want 300=11 304=22, no reads", wa_q.size() - wb, rd_q.size() - rb);
        end
        repeat (2) @(negedge CLK);
    endtask

    // Reset asserted while the second forwarded word is being written.
    task automatic test_reset_mid();
        int          k1, p0, wb, quiet_bad, k;
        bit          hit;
        logic [31:0] got [2];
        k1 = 0; p0 = 0; hit = 0; quiet_bad = 0; k = 0;
        wb = wa_q.size();
        daddr[31:0] = 32'h0000_0100;
        ccwrite[0]  = 1'b1;
        dREN[0]     = 1'b1;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge CLK);
            if (!dwait[1]) k1++;
            if (!dwait[0]) p0++;
            if (ccwait[1]) begin
                cctrans[1]    = 1'b1;
                dstore[63:32] = (k1 == 0) ? 32'h5555_0000 : 32'h5555_0004;
            end
            if (p0 >= 1 && ramWEN) hit = 1;
        end
        total++; if (!hit) begin bad++; $display("FAIL rstmid_timeout: second word write never seen"); end
        nRST = 1'b0;
        idle_inputs();
        @(negedge CLK);
        total++; if ({dwait, ccwait, ccinv} !== 6'b11_00_00) begin
            bad++; $display("FAIL rstmid_handshake: got %b want 110000", {dwait, ccwait, ccinv});
        end
        total++; if ({ramREN, ramWEN} !== 2'b00 || dload !== 64'h0 || ccsnoopaddr !== 64'h0) begin
            bad++; $display("FAIL rstmid_outputs: ram %b dload %h snoop %h want 00 0 0", {ramREN, ramWEN}, dload, ccsnoopaddr);
        end
        total++; if (wa_q.size() - wb != 1 || wd_q[wb] !== 32'h5555_0000) begin
            bad++; $display("FAIL rstmid_writes: got %0d writes want 1 (100=55550000)", wa_q.size() - wb);
        end
        nRST = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (ramREN || ramWEN || ccwait != 2'b00 || ccinv != 2'b00 || dwait != 2'b11) quiet_bad++;
        end
        total++; if (quiet_bad != 0) begin bad++; $display("FAIL rstmid_idle: busy cycles %0d want 0", quiet_bad); end
        // Core1 reads the block: forwarded word0 landed, abandoned word1 did not.
        daddr[63:32] = 32'h0000_0100;
        dREN[1]      = 1'b1;
        for (int c = 0; c < 100 && k < 2; c++) begin
            @(negedge CLK);
            if (!dwait[1]) begin got[k] = dload[63:32]; k++; end
        end
        idle_inputs();
        total++; if ({got[0], got[1]} !== {32'h5555_0000, 32'hCAFE_F00D}) begin
            bad++; $display("FAIL rstmid_after_read: got %h %h want 55550000 cafef00d", got[0], got[1]);
        end
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_read();
        test_c2c();
        test_inv();
        test_wb();
        test_reset_mid();
        total++; if (both_n != 0) begin bad++; $display("FAIL ram_ren_wen_overlap: got %0d cycles want 0", both_n); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
